// File: rtl/sram_access_sequencer.sv
// Clocked sequencer/arbiter for the SAP1 asynchronous SRAM: loader has priority over the CPU,
// every SRAM control pin is a register. Optional write read-back check under READBACK_VERIFY_EN.
module sram_access_sequencer #(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_req,
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_wdata,
    output logic       ld_ack,
    output logic [7:0] ld_rdata,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic       busy,
    output logic [7:0] A,
    inout  wire  [7:0] DQ,
    output logic       CE,
    output logic       WE,
    output logic       OE
`ifdef READBACK_VERIFY_EN
    ,
    output logic       verify_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACT,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HLD,
`ifdef READBACK_VERIFY_EN
        S_VFY_RD,
`endif
        S_DONE
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WP_LOAD = 4'(WR_PULSE - 1);
    localparam logic [3:0] WH_LOAD = 4'(WR_HOLD - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        last;
    logic        grant;
    logic        grant_ld;
    logic        sel_we;
    logic [7:0]  sel_addr;
    logic [7:0]  sel_wdata;
    logic [7:0]  wdata_q;
    logic        dq_oe;
    logic        ce_d, we_d, oe_d, dq_oe_d, ld_ack_d, cpu_ack_d, busy_d;

    function automatic logic [3:0] load_for(input state_t s);
        case (s)
            S_RD_ACT:   return RD_LOAD;
`ifdef READBACK_VERIFY_EN
            S_VFY_RD:   return RD_LOAD;
`endif
            S_WR_PULSE: return WP_LOAD;
            S_WR_HLD:   return WH_LOAD;
            default:    return 4'd0;
        endcase
    endfunction

    assign last      = (cnt == 4'd0);
    assign grant     = (state == S_IDLE) && (ld_req || cpu_req);
    assign sel_we    = ld_req ? ld_we    : cpu_we;
    assign sel_addr  = ld_req ? ld_addr  : cpu_addr;
    assign sel_wdata = ld_req ? ld_wdata : cpu_wdata;

    // DQ is only ever driven from a registered enable, never while OE is low
    assign DQ = dq_oe ? wdata_q : {8{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            CE      <= 1'b1;
            WE      <= 1'b1;
            OE      <= 1'b1;
            dq_oe   <= 1'b0;
            ld_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_nxt;
            CE      <= ce_d;
            WE      <= we_d;
            OE      <= oe_d;
            dq_oe   <= dq_oe_d;
            ld_ack  <= ld_ack_d;
            cpu_ack <= cpu_ack_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (ld_req || cpu_req) next_state = sel_we ? S_WR_SETUP : S_RD_ACT;
            S_RD_ACT:   if (last) next_state = S_DONE;
            S_WR_SETUP: next_state = S_WR_PULSE;
            S_WR_PULSE: if (last) next_state = S_WR_HLD;
`ifdef READBACK_VERIFY_EN
            S_WR_HLD:   if (last) next_state = S_VFY_RD;
            S_VFY_RD:   if (last) next_state = S_DONE;
`else
            S_WR_HLD:   if (last) next_state = S_DONE;
`endif
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
        // counter reloads on every state entry and counts down while the state is held
        cnt_nxt = cnt;
        if (next_state != state)
            cnt_nxt = load_for(next_state);
        else if (!last)
            cnt_nxt = cnt - 4'd1;
    end

    // outputs decoded from the next state so the pins change on the same edge as the state
    always_comb begin
        ce_d      = 1'b1;
        we_d      = 1'b1;
        oe_d      = 1'b1;
        dq_oe_d   = 1'b0;
        ld_ack_d  = 1'b0;
        cpu_ack_d = 1'b0;
        busy_d    = (next_state != S_IDLE);
        case (next_state)
            S_RD_ACT: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
            end
`ifdef READBACK_VERIFY_EN
            S_VFY_RD: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
            end
`endif
            S_WR_SETUP: begin
                ce_d    = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_WR_PULSE: begin
                ce_d    = 1'b0;
                we_d    = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_WR_HLD: begin
                ce_d    = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_DONE: begin
                ld_ack_d  = grant_ld;
                cpu_ack_d = !grant_ld;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A         <= 8'h00;
            grant_ld  <= 1'b0;
            ld_rdata  <= 8'h00;
            cpu_rdata <= 8'h00;
        end else begin
            if (grant) begin
                A        <= sel_addr;
                grant_ld <= ld_req;
            end
            if (state == S_RD_ACT && last) begin
                if (grant_ld)
                    ld_rdata <= DQ;
                else
                    cpu_rdata <= DQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            wdata_q <= sel_wdata;
    end

`ifdef READBACK_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            verify_err <= 1'b0;
        else if (state == S_VFY_RD && last && DQ != wdata_q)
            verify_err <= 1'b1;
    end
`endif

endmodule

// File: doc/sram_access_sequencer.md
Name: sram_access_sequencer

Overview:
- Clocked sequencer and arbiter for the SAP1 8-bit asynchronous SRAM (active-low CE/WE/OE, shared bidirectional DQ).
- Serves two requesters:
  - the manual programming panel (loader port);
  - the CPU memory port (fetch and operand read, plus STA write).
- Converts each single-cycle request into a correctly timed SRAM read or write.
- Guarantees DQ is never driven while OE is low.

Parameters:
- RD_WAIT, 2, number of clocks OE/CE are held low before DQ is sampled (1..15).
- WR_PULSE, 2, number of clocks WE is held low (1..15).
- WR_HOLD, 1, number of clocks DQ stays driven after WE rises (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_req  in  1  loader request, sampled high for one or more clocks.
- ld_we  in  1  loader: 1 = write, 0 = read.
- ld_addr  in  8  loader address.
- ld_wdata  in  8  loader write data.
- ld_ack  out  1  one-clock pulse when the loader transaction completes.
- ld_rdata  out  8  loader read data, valid with ld_ack.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  CPU: 1 = write, 0 = read.
- cpu_addr  in  8  CPU address (MAR).
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-clock completion pulse.
- cpu_rdata  out  8  CPU read data, valid with cpu_ack.
- busy  out  1  high whenever the FSM is not in IDLE.
- A  out  8  SRAM address.
- DQ  inout  8  SRAM data.
- CE  out  1  SRAM chip enable, active low.
- WE  out  1  SRAM write enable, active low.
- OE  out  1  SRAM output enable, active low.

Behaviour:
- Reset (async, rst_n low), all registered immediately:
  - state = IDLE;
  - CE = WE = OE = 1;
  - A = 0;
  - DQ released (Z);
  - ld_ack = cpu_ack = 0;
  - ld_rdata = cpu_rdata = 0;
  - busy = 0;
  - wait counter = 0.
- Reset mid-transaction aborts it; no ack is produced.
- Arbitration, evaluated only in IDLE:
  - loader has fixed priority over CPU;
  - the requester's addr, we and wdata are captured into internal registers on the grant edge;
  - the non-granted request stays pending (the requester must hold req high until ack);
  - after an ack, IDLE re-arbitrates on the next clock, so back-to-back transactions have 1 idle cycle between them.
- States:
  - IDLE:
    - CE = WE = OE = 1, DQ = Z.
    - On grant, latch A and go to RD_ACT if we = 0, else WR_SETUP.
  - RD_ACT:
    - CE = 0, OE = 0, WE = 1, DQ = Z.
    - Counter counts RD_WAIT clocks.
    - On the last clock, DQ is captured into the granted requester's rdata register and the FSM goes to DONE.
  - WR_SETUP (1 clock):
    - CE = 0, OE = 1, WE = 1.
    - DQ driven with the latched wdata, giving address/data setup before the WE falling edge.
  - WR_PULSE:
    - CE = 0, OE = 1, WE = 0, DQ driven.
    - Lasts WR_PULSE clocks.
  - WR_HLD:
    - CE = 0, OE = 1, WE = 1, DQ still driven.
    - Lasts WR_HOLD clocks, then DONE.
  - DONE (1 clock):
    - CE = WE = OE = 1, DQ = Z.
    - The granted requester's ack is high this clock only; next state IDLE.
- Latency from req sampled in IDLE to the ack clock:
  - read = 1 + RD_WAIT clocks;
  - write = 2 + WR_PULSE + WR_HOLD clocks.
- Invariants:
  - OE and WE are never both 0.
  - DQ is driven only in WR_SETUP, WR_PULSE and WR_HLD.
  - A is stable from grant until DONE.
  - All SRAM controls come from registers (glitch-free).
- Request changes:
  - req, addr or data changing after grant have no effect on the transaction in flight.
  - req dropping before ack: the transaction still completes and the ack is still pulsed.
- Simultaneous ld_req and cpu_req in IDLE: loader is served first, CPU next.
- rdata registers hold their value until the next read for that requester.
- Counters are 4 bits and load (parameter − 1) on state entry; a parameter of 1 gives exactly one clock.

Optional Feature:
- Macro: READBACK_VERIFY_EN.
- When defined:
  - Every write continues WR_HLD -> VFY_RD instead of DONE.
  - VFY_RD is the same as RD_ACT for RD_WAIT clocks.
  - The sampled DQ is compared with the latched wdata.
  - Extra output verify_err (1 bit, reset 0) is set on a mismatch and is sticky until reset.
  - The FSM then goes to DONE; write latency grows by RD_WAIT.
- When undefined:
  - No VFY_RD state and no verify_err port.
  - Write latency is as stated above.

Test Plan:
- Loader write then read, defaults:
  - Stimulus: ld_req, ld_we=1, addr 0x0F, data 0xA5; then ld_we=0, addr 0x0F.
  - Required: WE low for exactly 2 clocks with DQ = 0xA5 from 1 clock before WE falls to 1 clock after it rises; ld_ack 5 clocks after the request; the read acks after 3 clocks with ld_rdata = 0xA5.
- Arbitration:
  - Stimulus: ld_req and cpu_req asserted in the same clock, CPU reading 0x03 which holds 0x3C.
  - Required: loader acked first; cpu_ack follows after the idle cycle plus 3 clocks, with cpu_rdata = 0x3C.
- Bus safety:
  - Stimulus: random back-to-back reads and writes over 1000 transactions.
  - Required: assertions never fire for (OE==0 && WE==0) or DQ driven while OE==0; A constant from grant until ack.
- Async reset mid-write:
  - Stimulus: rst_n low during WR_PULSE.
  - Required: WE/CE/OE go to 1 and DQ to Z in the same clock; no ack; the next write to 0x20 completes normally.
- Parameter sweep:
  - Stimulus: RD_WAIT=1, WR_PULSE=4, WR_HOLD=2.
  - Required: read latency 2 clocks; WE low for 4 clocks; write latency 8 clocks.
- READBACK_VERIFY_EN:
  - Stimulus: the SRAM model forces bit 0 stuck at 0; write 0x01.
  - Required: verify_err rises at DONE and stays 1; writing 0x02 afterwards does not clear it.
